output_register_bank: RTL and testbench
=======================================

Name: output_register_bank

Overview:
- Parametrised bank of CHANNELS peripheral-bus output registers, each WIDTH bits wide.
- Each channel supports write, set, clear and toggle operations with byte masking.
- New over the single-register block:
  - optional shadow registers with an atomic commit to all channels;
  - per-channel hardware-timed pulses, where bits invert for a programmable cycle count and then revert automatically.
- Sits on the peripheral bus beside other register blocks; drives GPIO/peripheral control lines.

Parameters:
- WIDTH, 32, bits per channel (1..32)
- CHANNELS, 4, number of channels (1..16)
- ADDRESS, 8'h00, base page; block occupies pages ADDRESS..ADDRESS+2*CHANNELS
- DEFAULT, 32'h0, reset value of every channel's live and shadow value (low WIDTH bits used)
- PULSE_WIDTH, 8, width of the pulse length register and of each pulse counter
- SHADOWED, 0, 1 = channel ops target shadow registers and COMMIT copies them to live

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block select from peripheral decoder
- peripheralBus_we  in  1  write strobe
- peripheralBus_oe  in  1  read strobe
- peripheralBus_address  in  12  byte address; [11:4] page, [3:0] offset
- peripheralBus_byteSelect  in  4  byte lanes
- peripheralBus_dataRead  out  32  read data, 0 when not reading
- peripheralBus_dataWrite  in  32  write data
- requestOutput  out  1  high while this block drives read data
- currentValue  out  CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]; live ^ pulseMask
- pulseActive  out  CHANNELS  bit i high while channel i pulse counter is nonzero

Behaviour:
- Bus decode:
  - page p = address[11:4] - ADDRESS;
  - we = enable & we & !oe on a mapped page; oe = enable & oe & !we on a mapped page.
  - dataMask expands byteSelect per byte; maskedData = dataWrite & dataMask (low WIDTH bits).
- Channel page p in 0..CHANNELS-1, target T = shadow[p] if SHADOWED else live[p]:
  - 0x0 write: T <= maskedData | (T & ~mask)
  - 0x4 set: T |= maskedData
  - 0x8 clear: T &= ~maskedData
  - 0xC toggle: T ^= maskedData
  - Read of any offset returns T zero-padded to 32 bits.
- Pulse page p in CHANNELS..2*CHANNELS-1, channel c = p - CHANNELS:
  - Write at offset 0x0 with pulseLength != 0:
    - cnt[c] <= pulseLength;
    - pulseMask[c] <= (cnt[c] > 1 ? pulseMask[c] : 0) | maskedData.
    - The OR rule applies while a pulse is active, and the new write restarts the count.
  - Write with pulseLength == 0 is ignored.
  - Each cycle with cnt != 0 and no pulse write: cnt decrements; on the 1->0 step pulseMask clears in the same edge.
  - Read 0x0 returns pulseMask[c]; other offsets read 0, writes ignored.
- Control page p = 2*CHANNELS:
  - 0x0 COMMIT, write-only, reads 0: when SHADOWED=1, a write with byteSelect[0] and dataWrite[0]=1 sets live[i] <= shadow[i] for all i on that edge. No effect when SHADOWED=0.
  - 0x4 PULSE_LENGTH, R/W, PULSE_WIDTH bits, byte masked.
  - 0x8 PULSE_STATUS, read-only, bit i = pulseActive[i].
  - 0xC reads 0, writes ignored.
- Timing:
  - Write sampled at edge N; the new currentValue is visible after edge N.
  - A pulse with length L keeps bits inverted for exactly L cycles after edge N.
  - Reads are combinational in the strobe cycle: dataRead = data & dataMask when oe, else 0. requestOutput = oe.
- Live writes never clear an active pulse: currentValue = newLive ^ pulseMask.
- Pages outside the mapped range: no effect, dataRead 0, requestOutput 0.
- Reset, asynchronous, any time including mid-pulse:
  - live and shadow = DEFAULT; pulseMask, cnt and pulseActive = 0; pulseLength = 1;
  - dataRead = 0 and requestOutput = 0 whenever oe is low.

Test Plan:
- Reset with DEFAULT=32'hA5 and CHANNELS=4 -> every channel of currentValue = 8'hA5 (WIDTH=8), pulseActive=0, PULSE_LENGTH reads 1.
- Channel 2 write 32'h12345678 with byteSelect 4'b0101, then set 0x100, clear 0x8, toggle 0xFF000000 (WIDTH=32) -> each step's read value matches the masked arithmetic; channels 0, 1 and 3 are unchanged.
- PULSE_LENGTH=3; channel 1 live=0; pulse write 0x1 -> bit0 high for exactly 3 cycles, pulseActive[1] high for the same 3 cycles, PULSE_STATUS=0x2 during the pulse.
- Second pulse of 0x2 at count 2 -> mask=0x3 and count reloads to 3. Pulse write with PULSE_LENGTH=0 -> no change. Reset asserted mid-pulse -> outputs return to DEFAULT immediately.
- SHADOWED=1: write channels 0 and 1 -> currentValue unchanged and reads return shadow. COMMIT with data 1 -> both channels update on the same edge. COMMIT with data 0 -> no change.
- we and oe both high, enable low, or page out of range -> no state change, dataRead=0, requestOutput=0.

Source files
------------

// File: rtl/output_register_bank.sv
// output_register_bank
//   Bank of CHANNELS peripheral-bus output registers, WIDTH bits each, with
//   write / set / clear / toggle operations under byte masking. Optional
//   shadow registers are copied to the live outputs by a single COMMIT write.
//   Each channel also has a hardware-timed pulse: selected bits invert for
//   PULSE_LENGTH cycles and then revert on their own.
//
//   Page map (page = address[11:4] - ADDRESS):
//     0 .. CHANNELS-1            channel registers (0x0 write, 0x4 set, 0x8 clear, 0xC toggle)
//     CHANNELS .. 2*CHANNELS-1   pulse registers (0x0 pulse mask)
//     2*CHANNELS                 control (0x0 COMMIT, 0x4 PULSE_LENGTH, 0x8 PULSE_STATUS)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable                      block select from the peripheral decoder
//   peripheralBus_we / _oe      write / read strobes
//   peripheralBus_address       byte address, [11:4] page, [3:0] offset
//   peripheralBus_byteSelect    byte lanes
//   peripheralBus_dataWrite     write data
//   peripheralBus_dataRead      read data, 0 when not reading
//   requestOutput               high while this block drives read data
//   currentValue                channel i at [i*WIDTH +: WIDTH], live ^ pulse mask
//   pulseActive                 bit i high while channel i pulse is running
module output_register_bank #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 4,
  parameter logic [7:0]  ADDRESS     = 8'h00,
  parameter logic [31:0] DEFAULT     = 32'h0,
  parameter int unsigned PULSE_WIDTH = 8,
  parameter bit          SHADOWED    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      peripheralBus_we,
  input  logic                      peripheralBus_oe,
  input  logic [11:0]               peripheralBus_address,
  input  logic [3:0]                peripheralBus_byteSelect,
  output logic [31:0]               peripheralBus_dataRead,
  input  logic [31:0]               peripheralBus_dataWrite,
  output logic                      requestOutput,
  output logic [CHANNELS*WIDTH-1:0] currentValue,
  output logic [CHANNELS-1:0]       pulseActive
);

  localparam logic [7:0]             PULSE_BASE  = 8'(CHANNELS);
  localparam logic [7:0]             CTRL_PAGE   = 8'(2 * CHANNELS);
  localparam logic [WIDTH-1:0]       RESET_VALUE = DEFAULT[WIDTH-1:0];
  localparam logic [PULSE_WIDTH-1:0] PULSE_ONE   = PULSE_WIDTH'(1);

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_SET    = 4'h4;
  localparam logic [3:0] OFF_CLEAR  = 4'h8;
  localparam logic [3:0] OFF_TOGGLE = 4'hC;

  // ---------------------------------------------------------------- decode
  logic [7:0]             page;
  logic [3:0]             offset;
  logic                   mapped;
  logic                   busWe;
  logic                   busOe;
  logic [31:0]            dataMask;
  logic [WIDTH-1:0]       writeMask;
  logic [WIDTH-1:0]       maskedData;
  logic [PULSE_WIDTH-1:0] lengthMask;
  logic [PULSE_WIDTH-1:0] lengthData;
  logic                   commitWe;
  logic [PULSE_WIDTH-1:0] pulseLength;
  logic [31:0]            readChan [CHANNELS];
  logic [31:0]            readData;

  // Subtraction wraps, so pages below the base land far above CTRL_PAGE
  // and fall out of the mapped range.
  assign page   = peripheralBus_address[11:4] - ADDRESS;
  assign offset = peripheralBus_address[3:0];
  assign mapped = (page <= CTRL_PAGE);
  assign busWe  = enable & peripheralBus_we & ~peripheralBus_oe & mapped;
  assign busOe  = enable & peripheralBus_oe & ~peripheralBus_we & mapped;

  always_comb begin
    dataMask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      dataMask[b*8 +: 8] = {8{peripheralBus_byteSelect[b]}};
    end
  end

  assign writeMask  = dataMask[WIDTH-1:0];
  assign maskedData = peripheralBus_dataWrite[WIDTH-1:0] & writeMask;
  assign lengthMask = dataMask[PULSE_WIDTH-1:0];
  assign lengthData = peripheralBus_dataWrite[PULSE_WIDTH-1:0] & lengthMask;

  assign commitWe = SHADOWED && busWe && (page == CTRL_PAGE) && (offset == OFF_DATA) &&
                    peripheralBus_byteSelect[0] && peripheralBus_dataWrite[0];

  // ---------------------------------------------------------------- channels
  for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
    logic                   chSel;
    logic                   pulseSel;
    logic                   chWe;
    logic                   pulseWe;
    logic [WIDTH-1:0]       liveReg;
    logic [WIDTH-1:0]       shadowReg;
    logic [WIDTH-1:0]       target;
    logic [WIDTH-1:0]       nextTarget;
    logic [WIDTH-1:0]       pulseMask;
    logic [PULSE_WIDTH-1:0] pulseCount;

    assign chSel    = (page == 8'(i));
    assign pulseSel = (page == PULSE_BASE + 8'(i));
    assign chWe     = busWe && chSel;
    assign pulseWe  = busWe && pulseSel && (offset == OFF_DATA) && (pulseLength != '0);
    assign target   = SHADOWED ? shadowReg : liveReg;

    always_comb begin
      nextTarget = target;
      case (offset)
        OFF_DATA:   nextTarget = maskedData | (target & ~writeMask);
        OFF_SET:    nextTarget = target | maskedData;
        OFF_CLEAR:  nextTarget = target & ~maskedData;
        OFF_TOGGLE: nextTarget = target ^ maskedData;
        default:    nextTarget = target;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        liveReg   <= RESET_VALUE;
        shadowReg <= RESET_VALUE;
      end else if (chWe) begin
        if (SHADOWED) shadowReg <= nextTarget;
        else          liveReg   <= nextTarget;
      end else if (commitWe) begin
        liveReg <= shadowReg;
      end
    end

    // A new pulse write merges with the running mask only while the old
    // pulse still has more than this edge to go; on its final cycle the old
    // mask is dropped and only the new bits start.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pulseCount <= '0;
        pulseMask  <= '0;
      end else if (pulseWe) begin
        pulseCount <= pulseLength;
        pulseMask  <= ((pulseCount > PULSE_ONE) ? pulseMask : '0) | maskedData;
      end else if (pulseCount != '0) begin
        pulseCount <= pulseCount - PULSE_ONE;
        if (pulseCount == PULSE_ONE) pulseMask <= '0;
      end
    end

    assign currentValue[i*WIDTH +: WIDTH] = liveReg ^ pulseMask;
    assign pulseActive[i]                 = (pulseCount != '0);
    assign readChan[i] = chSel                             ? 32'(target)    :
                         (pulseSel && offset == OFF_DATA)  ? 32'(pulseMask) : '0;
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulseLength <= PULSE_ONE;
    end else if (busWe && (page == CTRL_PAGE) && (offset == OFF_SET)) begin
      pulseLength <= lengthData | (pulseLength & ~lengthMask);
    end
  end

  // ---------------------------------------------------------------- read path
  always_comb begin
    readData = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      readData = readData | readChan[c];
    end
    if (page == CTRL_PAGE) begin
      case (offset)
        OFF_SET:   readData = 32'(pulseLength);
        OFF_CLEAR: readData = 32'(pulseActive);
        default:   readData = '0;
      endcase
    end
  end

  assign peripheralBus_dataRead = busOe ? (readData & dataMask) : '0;
  assign requestOutput          = busOe;

  logic unusedBits;
  assign unusedBits = ^peripheralBus_dataWrite;

endmodule

// File: tb/tb_output_register_bank.sv
module tb_output_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en0, en1, en2;
  logic        we, oe;
  logic [11:0] addr;
  logic [3:0]  bsel;
  logic [31:0] wdata;

  logic [31:0]  rd0, rd1, rd2;
  logic         req0, req1, req2;
  logic [31:0]  cur0;
  logic [127:0] cur1, cur2;
  logic [3:0]   pa0, pa1, pa2;

  // u0: 8-bit channels with a nonzero default, used for reset and pulse tests
  output_register_bank #(
    .WIDTH(8), .CHANNELS(4), .ADDRESS(8'h00), .DEFAULT(32'hA5),
    .PULSE_WIDTH(8), .SHADOWED(1'b0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .enable(en0),
    .peripheralBus_we(we), .peripheralBus_oe(oe),
    .peripheralBus_address(addr), .peripheralBus_byteSelect(bsel),
    .peripheralBus_dataRead(rd0), .peripheralBus_dataWrite(wdata),
    .requestOutput(req0), .currentValue(cur0), .pulseActive(pa0)
  );

  // u1: 32-bit channels, direct (unshadowed) register arithmetic
  output_register_bank #(
    .WIDTH(32), .CHANNELS(4), .ADDRESS(8'h20), .DEFAULT(32'h0),
    .PULSE_WIDTH(8), .SHADOWED(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .enable(en1),
    .peripheralBus_we(we), .peripheralBus_oe(oe),
    .peripheralBus_address(addr), .peripheralBus_byteSelect(bsel),
    .peripheralBus_dataRead(rd1), .peripheralBus_dataWrite(wdata),
    .requestOutput(req1), .currentValue(cur1), .pulseActive(pa1)
  );

  // u2: shadowed bank with atomic commit
  output_register_bank #(
    .WIDTH(32), .CHANNELS(4), .ADDRESS(8'h40), .DEFAULT(32'h11),
    .PULSE_WIDTH(8), .SHADOWED(1'b1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .enable(en2),
    .peripheralBus_we(we), .peripheralBus_oe(oe),
    .peripheralBus_address(addr), .peripheralBus_byteSelect(bsel),
    .peripheralBus_dataRead(rd2), .peripheralBus_dataWrite(wdata),
    .requestOutput(req2), .currentValue(cur2), .pulseActive(pa2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleBus();
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    we = 1'b0; oe = 1'b0;
  endtask

  task automatic selectDut(input int d);
    en0 = (d == 0); en1 = (d == 1); en2 = (d == 2);
  endtask

  // Write sampled on the next rising edge; returns 1 time unit after it.
  task automatic busWrite(input int d, input logic [11:0] a, input logic [3:0] bs,
                          input logic [31:0] data);
    @(negedge clk);
    selectDut(d);
    we = 1'b1; oe = 1'b0; addr = a; bsel = bs; wdata = data;
    @(posedge clk);
    #1;
    idleBus();
  endtask

  // Combinational read inside the current cycle.
  task automatic busRead(input int d, input logic [11:0] a, input logic [3:0] bs,
                         output logic [31:0] data, output logic req);
    selectDut(d);
    we = 1'b0; oe = 1'b1; addr = a; bsel = bs;
    #1;
    case (d)
      0:       begin data = rd0; req = req0; end
      1:       begin data = rd1; req = req1; end
      default: begin data = rd2; req = req2; end
    endcase
    idleBus();
  endtask

  task automatic expectRead(input string name, input int d, input logic [11:0] a,
                            input logic [31:0] exp);
    logic [31:0] data;
    logic        req;
    busRead(d, a, 4'hF, data, req);
    check({name, " data"}, 128'(data), 128'(exp));
    check({name, " req"}, 128'(req), 128'(1'b1));
  endtask

  typedef struct {
    string        name;
    logic         en;
    logic         we;
    logic         oe;
    logic [11:0]  addr;
    logic [3:0]   bs;
    logic [31:0]  wdata;
    logic [31:0]  expRead;
    logic         expReq;
    logic [127:0] expCur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic e, input logic w, input logic o,
                              input logic [11:0] a, input logic [3:0] b, input logic [31:0] d,
                              input logic [31:0] er, input logic eq, input logic [31:0] ch2);
    vec_t v;
    v.name = n; v.en = e; v.we = w; v.oe = o; v.addr = a; v.bs = b; v.wdata = d;
    v.expRead = er; v.expReq = eq;
    v.expCur = {32'h0, ch2, 64'h0};
    return v;
  endfunction

  localparam logic [127:0] U2_RESET = {4{32'h11}};

  initial begin
    rst_n = 1'b0;
    idleBus();
    addr = '0; bsel = '0; wdata = '0;

    // ---------------------------------------------------------- reset state
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset u0 cur", 128'(cur0), 128'(32'hA5A5A5A5));
    check("reset u0 pulseActive", 128'(pa0), 128'(4'h0));
    check("reset u1 cur", cur1, 128'h0);
    check("reset u2 cur", cur2, U2_RESET);
    expectRead("reset u0 PULSE_LENGTH", 0, 12'h084, 32'h1);
    expectRead("reset u2 PULSE_LENGTH", 2, 12'h484, 32'h1);

    // ---------------------------------------------------------- u1 table
    vecs.push_back(mk("rd ch2 reset", 1, 0, 1, 12'h220, 4'hF, 32'h0,       32'h0,        1, 32'h0));
    vecs.push_back(mk("wr ch2 bs5",   1, 1, 0, 12'h220, 4'h5, 32'h12345678, 32'h0,       0, 32'h00340078));
    vecs.push_back(mk("rd after wr",  1, 0, 1, 12'h220, 4'hF, 32'h0,       32'h00340078, 1, 32'h00340078));
    vecs.push_back(mk("rd lanes 01",  1, 0, 1, 12'h22C, 4'h3, 32'h0,       32'h00000078, 1, 32'h00340078));
    vecs.push_back(mk("set 0x100",    1, 1, 0, 12'h224, 4'hF, 32'h100,     32'h0,        0, 32'h00340178));
    vecs.push_back(mk("rd after set", 1, 0, 1, 12'h224, 4'hF, 32'h0,       32'h00340178, 1, 32'h00340178));
    vecs.push_back(mk("clear 0x8",    1, 1, 0, 12'h228, 4'hF, 32'h8,       32'h0,        0, 32'h00340170));
    vecs.push_back(mk("rd after clr", 1, 0, 1, 12'h228, 4'hF, 32'h0,       32'h00340170, 1, 32'h00340170));
    vecs.push_back(mk("toggle top",   1, 1, 0, 12'h22C, 4'hF, 32'hFF000000, 32'h0,       0, 32'hFF340170));
    vecs.push_back(mk("rd after tgl", 1, 0, 1, 12'h220, 4'hF, 32'h0,       32'hFF340170, 1, 32'hFF340170));
    vecs.push_back(mk("rd ch0",       1, 0, 1, 12'h200, 4'hF, 32'h0,       32'h0,        1, 32'hFF340170));
    vecs.push_back(mk("rd ch3",       1, 0, 1, 12'h230, 4'hF, 32'h0,       32'h0,        1, 32'hFF340170));
    vecs.push_back(mk("wr no lanes",  1, 1, 0, 12'h200, 4'h0, 32'hFFFFFFFF, 32'h0,       0, 32'hFF340170));
    vecs.push_back(mk("we and oe",    1, 1, 1, 12'h220, 4'hF, 32'h0,       32'h0,        0, 32'hFF340170));
    vecs.push_back(mk("wr enable off",0, 1, 0, 12'h220, 4'hF, 32'h0,       32'h0,        0, 32'hFF340170));
    vecs.push_back(mk("rd enable off",0, 0, 1, 12'h220, 4'hF, 32'h0,       32'h0,        0, 32'hFF340170));
    vecs.push_back(mk("wr page high", 1, 1, 0, 12'h290, 4'hF, 32'hFFFFFFFF, 32'h0,       0, 32'hFF340170));
    vecs.push_back(mk("wr page low",  1, 1, 0, 12'h1F0, 4'hF, 32'hFFFFFFFF, 32'h0,       0, 32'hFF340170));
    vecs.push_back(mk("rd page high", 1, 0, 1, 12'h290, 4'hF, 32'h0,       32'h0,        0, 32'hFF340170));
    vecs.push_back(mk("rd page low",  1, 0, 1, 12'h1F0, 4'hF, 32'h0,       32'h0,        0, 32'hFF340170));
    vecs.push_back(mk("rd length",    1, 0, 1, 12'h284, 4'hF, 32'h0,       32'h1,        1, 32'hFF340170));
    vecs.push_back(mk("rd commit",    1, 0, 1, 12'h280, 4'hF, 32'h0,       32'h0,        1, 32'hFF340170));
    vecs.push_back(mk("rd ctrl 0xC",  1, 0, 1, 12'h28C, 4'hF, 32'h0,       32'h0,        1, 32'hFF340170));
    vecs.push_back(mk("rd status",    1, 0, 1, 12'h288, 4'hF, 32'h0,       32'h0,        1, 32'hFF340170));
    vecs.push_back(mk("rd pulse c0",  1, 0, 1, 12'h240, 4'hF, 32'h0,       32'h0,        1, 32'hFF340170));
    vecs.push_back(mk("rd pulse 0x4", 1, 0, 1, 12'h244, 4'hF, 32'h0,       32'h0,        1, 32'hFF340170));
    vecs.push_back(mk("wr length b0", 1, 1, 0, 12'h284, 4'h1, 32'h00000107, 32'h0,       0, 32'hFF340170));
    vecs.push_back(mk("rd length 7",  1, 0, 1, 12'h284, 4'hF, 32'h0,       32'h7,        1, 32'hFF340170));
    vecs.push_back(mk("toggle lane3", 1, 1, 0, 12'h22C, 4'h8, 32'hFFFFFFFF, 32'h0,       0, 32'h00340170));
    vecs.push_back(mk("rd lane3 tgl", 1, 0, 1, 12'h220, 4'hF, 32'h0,       32'h00340170, 1, 32'h00340170));

    foreach (vecs[k]) begin
      @(negedge clk);
      en1 = vecs[k].en; we = vecs[k].we; oe = vecs[k].oe;
      addr = vecs[k].addr; bsel = vecs[k].bs; wdata = vecs[k].wdata;
      #1;
      check({vecs[k].name, " dataRead"}, 128'(rd1), 128'(vecs[k].expRead));
      check({vecs[k].name, " requestOutput"}, 128'(req1), 128'(vecs[k].expReq));
      @(posedge clk);
      #1;
      check({vecs[k].name, " currentValue"}, cur1, vecs[k].expCur);
      idleBus();
    end

    // ---------------------------------------------------------- shadow / commit
    busWrite(2, 12'h400, 4'hF, 32'hAAAA5555);
    check("shadow wr ch0 live", cur2, U2_RESET);
    busWrite(2, 12'h414, 4'hF, 32'h100);
    check("shadow set ch1 live", cur2, U2_RESET);
    expectRead("shadow rd ch0", 2, 12'h400, 32'hAAAA5555);
    expectRead("shadow rd ch1", 2, 12'h418, 32'h00000111);
    busWrite(2, 12'h480, 4'h1, 32'h0);
    check("commit data0", cur2, U2_RESET);
    busWrite(2, 12'h480, 4'h0, 32'h1);
    check("commit no lane0", cur2, U2_RESET);
    busWrite(2, 12'h480, 4'h1, 32'h1);
    check("commit", cur2, {32'h11, 32'h11, 32'h111, 32'hAAAA5555});
    expectRead("commit reads 0", 2, 12'h480, 32'h0);

    // ---------------------------------------------------------- pulses on u0
    busWrite(0, 12'h084, 4'h1, 32'h3);
    expectRead("length 3", 0, 12'h084, 32'h3);
    busWrite(0, 12'h010, 4'hF, 32'h0);
    check("ch1 live 0", 128'(cur0), 128'(32'hA5A500A5));

    busWrite(0, 12'h050, 4'hF, 32'h1);
    check("pulse c1", 128'(cur0), 128'(32'hA5A501A5));
    check("pulse c1 active", 128'(pa0), 128'(4'h2));
    expectRead("pulse status", 0, 12'h088, 32'h2);
    expectRead("pulse mask rd", 0, 12'h050, 32'h1);
    for (int cyc = 2; cyc <= 4; cyc++) begin
      @(posedge clk);
      #1;
      check($sformatf("pulse c%0d", cyc), 128'(cur0),
            128'((cyc <= 3) ? 32'hA5A501A5 : 32'hA5A500A5));
      check($sformatf("pulse active c%0d", cyc), 128'(pa0),
            128'((cyc <= 3) ? 4'h2 : 4'h0));
    end

    busWrite(0, 12'h050, 4'hF, 32'h1);
    @(posedge clk);
    #1;
    check("retrigger before", 128'(cur0), 128'(32'hA5A501A5));
    busWrite(0, 12'h050, 4'hF, 32'h2);
    check("retrigger merge", 128'(cur0), 128'(32'hA5A503A5));
    check("retrigger active", 128'(pa0), 128'(4'h2));
    expectRead("retrigger mask", 0, 12'h050, 32'h3);
    for (int cyc = 2; cyc <= 4; cyc++) begin
      @(posedge clk);
      #1;
      check($sformatf("retrigger c%0d", cyc), 128'(cur0),
            128'((cyc <= 3) ? 32'hA5A503A5 : 32'hA5A500A5));
    end
    check("retrigger done", 128'(pa0), 128'(4'h0));

    busWrite(0, 12'h084, 4'h1, 32'h0);
    expectRead("length 0", 0, 12'h084, 32'h0);
    busWrite(0, 12'h050, 4'hF, 32'hFF);
    check("zero length ignored", 128'(cur0), 128'(32'hA5A500A5));
    check("zero length inactive", 128'(pa0), 128'(4'h0));

    busWrite(0, 12'h084, 4'h1, 32'h5);
    busWrite(0, 12'h050, 4'hF, 32'h80);
    check("long pulse", 128'(cur0), 128'(32'hA5A580A5));
    busWrite(0, 12'h010, 4'hF, 32'h0F);
    check("live wr under pulse", 128'(cur0), 128'(32'hA5A58FA5));
    check("live wr keeps active", 128'(pa0), 128'(4'h2));

    // ---------------------------------------------------------- reset mid-pulse
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset u0 cur", 128'(cur0), 128'(32'hA5A5A5A5));
    check("midreset u0 active", 128'(pa0), 128'(4'h0));
    check("midreset u1 cur", cur1, 128'h0);
    check("midreset u2 cur", cur2, U2_RESET);
    expectRead("midreset length", 0, 12'h084, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset u0 cur", 128'(cur0), 128'(32'hA5A5A5A5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
